// File: rtl/pc_seq_pkg.sv
// Shared definitions for the banked-PC control-flow sequencer:
// sizes, request opcodes, fault causes and FSM state encoding.
package pc_seq_pkg;

    localparam int PCW   = 9;
    localparam int DEPTH = 8;

    typedef enum logic [2:0] {
        OP_NEXT   = 3'd0,
        OP_JUMP   = 3'd1,
        OP_BRANCH = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4,
        OP_HALT   = 3'd5
    } op_e;

    localparam logic [2:0] FC_NONE      = 3'd0;
    localparam logic [2:0] FC_OVERFLOW  = 3'd1;
    localparam logic [2:0] FC_UNDERFLOW = 3'd2;
    localparam logic [2:0] FC_ILLEGAL   = 3'd3;
    localparam logic [2:0] FC_PC_ERR    = 3'd4;

    typedef enum logic [2:0] {
        S_INIT_UP   = 3'd0,
        S_INIT_TOP  = 3'd1,
        S_INIT_DOWN = 3'd2,
        S_IDLE      = 3'd3,
        S_CALL2     = 3'd4,
        S_HALT      = 3'd5,
        S_FAULT     = 3'd6
    } state_e;

endpackage

// File: rtl/pc_sequencer.sv
// Control-flow sequencer: scrubs the PC bank after reset, then turns decoded
// requests into PC bank increment/set/pointer controls while tracking call depth.
module pc_sequencer #(
    parameter int DEPTH = pc_seq_pkg::DEPTH,
    parameter int PCW   = pc_seq_pkg::PCW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [2:0]     req_op,
    input  logic [PCW-1:0] req_target,
    input  logic           req_taken,
    output logic           pc_inc,
    output logic           pc_inc_ref,
    output logic           pc_dec_ref,
    output logic           pc_set,
    output logic [PCW-1:0] pc_set_value,
    input  logic           pc_err,
    output logic [2:0]     depth,
    output logic           fetch_valid,
    output logic           halted,
    output logic           fault,
    output logic [2:0]     fault_code
);
    import pc_seq_pkg::*;

    localparam int                CNTW       = $clog2(DEPTH);
    localparam logic [CNTW-1:0]   SCRUB_LAST = CNTW'(DEPTH - 2);
    localparam logic [2:0]        MAX_DEPTH  = 3'(DEPTH - 1);

    state_e          state_reg, state_next;
    logic [CNTW-1:0] cnt_reg, cnt_next;
    logic [2:0]      depth_reg, depth_next;
    logic [PCW-1:0]  target_reg, target_next;
    logic [2:0]      fault_code_reg, fault_code_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_INIT_UP;
            cnt_reg        <= '0;
            depth_reg      <= '0;
            target_reg     <= '0;
            fault_code_reg <= FC_NONE;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            depth_reg      <= depth_next;
            target_reg     <= target_next;
            fault_code_reg <= fault_code_next;
        end
    end

    // Controls are qualified by rst_n so they drop to zero the moment reset asserts.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        depth_next      = depth_reg;
        target_next     = target_reg;
        fault_code_next = fault_code_reg;
        req_ready       = 1'b0;
        fetch_valid     = 1'b0;
        pc_inc          = 1'b0;
        pc_inc_ref      = 1'b0;
        pc_dec_ref      = 1'b0;
        pc_set          = 1'b0;
        pc_set_value    = '0;
        if (rst_n) begin
            if (pc_err && state_reg != S_FAULT) begin
                state_next      = S_FAULT;
                fault_code_next = FC_PC_ERR;
            end else begin
                case (state_reg)
                    S_INIT_UP: begin
                        pc_set     = 1'b1;
                        pc_inc_ref = 1'b1;
                        if (cnt_reg == SCRUB_LAST) begin
                            cnt_next   = '0;
                            state_next = S_INIT_TOP;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                    S_INIT_TOP: begin
                        pc_set     = 1'b1;
                        state_next = S_INIT_DOWN;
                    end
                    S_INIT_DOWN: begin
                        pc_dec_ref = 1'b1;
                        if (cnt_reg == SCRUB_LAST) begin
                            cnt_next   = '0;
                            state_next = S_IDLE;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                    S_IDLE: begin
                        req_ready   = 1'b1;
                        fetch_valid = 1'b1;
                        if (req_valid) begin
                            case (req_op)
                                OP_NEXT: pc_inc = 1'b1;
                                OP_JUMP: begin
                                    pc_set       = 1'b1;
                                    pc_set_value = req_target;
                                end
                                OP_BRANCH: begin
                                    if (req_taken) begin
                                        pc_set       = 1'b1;
                                        pc_set_value = req_target;
                                    end else begin
                                        pc_inc = 1'b1;
                                    end
                                end
                                OP_CALL: begin
                                    if (depth_reg == MAX_DEPTH) begin
                                        state_next      = S_FAULT;
                                        fault_code_next = FC_OVERFLOW;
                                    end else begin
                                        // Bump the return address in place, then move to the callee entry.
                                        pc_inc      = 1'b1;
                                        pc_inc_ref  = 1'b1;
                                        target_next = req_target;
                                        depth_next  = depth_reg + 3'd1;
                                        state_next  = S_CALL2;
                                    end
                                end
                                OP_RET: begin
                                    if (depth_reg == 3'd0) begin
                                        state_next      = S_FAULT;
                                        fault_code_next = FC_UNDERFLOW;
                                    end else begin
                                        pc_dec_ref = 1'b1;
                                        depth_next = depth_reg - 3'd1;
                                    end
                                end
                                OP_HALT: state_next = S_HALT;
                                default: begin
                                    state_next      = S_FAULT;
                                    fault_code_next = FC_ILLEGAL;
                                end
                            endcase
                        end
                    end
                    S_CALL2: begin
                        pc_set       = 1'b1;
                        pc_set_value = target_reg;
                        state_next   = S_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign depth      = depth_reg;
    assign halted     = (state_reg == S_HALT);
    assign fault      = (state_reg == S_FAULT);
    assign fault_code = fault_code_reg;

endmodule
